// File: rtl/tail_light_pkg.sv
// Shared types and defaults for the tail-light input conditioner and sequencer FSM.
package tail_light_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_HAZARD,
    CMD_BRAKE
  } cmd_t;

  localparam int DB_COUNT_DEF = 50_000;
  localparam int DB_W_DEF     = 16;
  localparam int TICK_DIV_DEF = 12_500_000;
  localparam int TICK_W_DEF   = 24;

  // Bit positions in the debug vector of debounced switch levels.
  localparam int IDX_LEFT   = 0;
  localparam int IDX_RIGHT  = 1;
  localparam int IDX_HAZARD = 2;
  localparam int IDX_BRAKE  = 3;

  // Left+right together is treated as a hazard request and outranks brake.
  function automatic cmd_t arbitrate(input logic l, input logic r, input logic h, input logic b);
    if (h || (l && r)) return CMD_HAZARD;
    else if (b)        return CMD_BRAKE;
    else if (l)        return CMD_LEFT;
    else if (r)        return CMD_RIGHT;
    else               return CMD_IDLE;
  endfunction

endpackage

// File: rtl/turn_signal_input_conditioner_if.sv
// Switch-side and sequencer-side signals of the turn-signal input conditioner.
interface turn_signal_input_conditioner_if;
  import tail_light_pkg::*;

  // No handshake: raw_* are free-running asynchronous levels; left/right/hazard/brake are
  // levels that change only on the edge where tick is high; tick is a one-clk pulse.
  logic       raw_left;
  logic       raw_right;
  logic       raw_hazard;
  logic       raw_brake;
  logic       left;
  logic       right;
  logic       hazard;
  logic       brake;
  logic       tick;
  cmd_t       cmd;
  logic [3:0] db_stable;

  modport master (
    output raw_left, raw_right, raw_hazard, raw_brake,
    input  left, right, hazard, brake, tick, cmd, db_stable
  );

  modport slave (
    input  raw_left, raw_right, raw_hazard, raw_brake,
    output left, right, hazard, brake, tick, cmd, db_stable
  );

endinterface

// File: rtl/turn_signal_input_conditioner_switch_debounce.sv
// Two-flop synchroniser plus counter debounce for one bouncing switch input.
module switch_debounce
  import tail_light_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEF,
  parameter int DB_W     = DB_W_DEF
) (
  input  logic clk,
  input  logic Reset,
  input  logic raw,
  output logic stable
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

  logic            meta_q;
  logic            sync_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Any cycle where sync agrees with stable restarts the count, so short glitches vanish.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/turn_signal_input_conditioner.sv
// Conditions the four tail-light switches into one command that changes only on the step tick.
module turn_signal_input_conditioner
  import tail_light_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEF,
  parameter int DB_W     = DB_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int TICK_W   = TICK_W_DEF
) (
  input logic                            clk,
  input logic                            Reset,
  turn_signal_input_conditioner_if.slave sw
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic              db_left, db_right, db_hazard, db_brake;
  logic [TICK_W-1:0] pcnt_q, pcnt_d;
  logic              tick;
  cmd_t              arb_cmd;
  cmd_t              cmd_q, cmd_d;

  switch_debounce #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_left (
    .clk(clk), .Reset(Reset), .raw(sw.raw_left), .stable(db_left)
  );
  switch_debounce #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_right (
    .clk(clk), .Reset(Reset), .raw(sw.raw_right), .stable(db_right)
  );
  switch_debounce #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_hazard (
    .clk(clk), .Reset(Reset), .raw(sw.raw_hazard), .stable(db_hazard)
  );
  switch_debounce #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_brake (
    .clk(clk), .Reset(Reset), .raw(sw.raw_brake), .stable(db_brake)
  );

  assign tick    = (pcnt_q == TICK_LAST);
  assign pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
  assign arb_cmd = arbitrate(db_left, db_right, db_hazard, db_brake);
  // A stable change landing on the tick edge misses this load and waits a full step.
  assign cmd_d   = tick ? arb_cmd : cmd_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pcnt_q <= '0;
      cmd_q  <= CMD_IDLE;
    end else begin
      pcnt_q <= pcnt_d;
      cmd_q  <= cmd_d;
    end
  end

  assign sw.left      = (cmd_q == CMD_LEFT);
  assign sw.right     = (cmd_q == CMD_RIGHT);
  assign sw.hazard    = (cmd_q == CMD_HAZARD);
  assign sw.brake     = (cmd_q == CMD_BRAKE);
  assign sw.tick      = tick;
  assign sw.cmd       = cmd_q;
  assign sw.db_stable = {db_brake, db_hazard, db_right, db_left};

endmodule

// File: tb/tb_turn_signal_input_conditioner.sv
// Directed bench for turn_signal_input_conditioner with DB_COUNT=4, TICK_DIV=8.
module tb_turn_signal_input_conditioner;
  import tail_light_pkg::*;

  localparam int DB_COUNT = 4;
  localparam int DB_W     = 3;
  localparam int TICK_DIV = 8;
  localparam int TICK_W   = 3;

  logic clk;
  logic Reset;
  int   checks;
  int   failures;

  turn_signal_input_conditioner_if bus ();

  turn_signal_input_conditioner #(
    .DB_COUNT(DB_COUNT), .DB_W(DB_W), .TICK_DIV(TICK_DIV), .TICK_W(TICK_W)
  ) dut (
    .clk(clk), .Reset(Reset), .sw(bus)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Order {brake, hazard, right, left} for both vectors.
  function automatic logic [3:0] outs();
    return {bus.brake, bus.hazard, bus.right, bus.left};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_raw(input logic l, input logic r, input logic h, input logic b);
    bus.raw_left   = l;
    bus.raw_right  = r;
    bus.raw_hazard = h;
    bus.raw_brake  = b;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a sampled tick, then moves past the edge that loads the command.
  task automatic wait_tick_load(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      if (bus.tick === 1'b1) begin
        seen = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    set_raw(1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    check("rst_outs", {28'd0, outs()}, 32'h0);
    check("rst_tick", {31'd0, bus.tick}, 32'd0);
    check("rst_db", {28'd0, bus.db_stable}, 32'h0);

    // 1: idle after release; iteration i samples after the i-th posedge (cycle i+1).
    Reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("t1_outs", {28'd0, outs()}, 32'h0);
      check("t1_tick", {31'd0, bus.tick}, {31'd0, (i == 7 || i == 15)});
    end

    // 2: left qualifies exactly 6 edges after the raw change, then loads on the next tick.
    set_raw(1'b1, 1'b0, 1'b0, 1'b0);
    step(5);
    check("t2_db_before", {28'd0, bus.db_stable}, 32'h0);
    step(1);
    check("t2_db_after", {28'd0, bus.db_stable}, 32'h1);
    check("t2_outs_pre", {28'd0, outs()}, 32'h0);
    wait_tick_load("t2_tick");
    check("t2_outs", {28'd0, outs()}, 32'h1);

    // 3: three-cycle right pulse is rejected; counter peaks at 3 then clears.
    set_raw(1'b1, 1'b1, 1'b0, 1'b0);
    step(3);
    set_raw(1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    check("t3_cnt_peak", {29'd0, dut.u_db_right.cnt_q}, 32'd3);
    check("t3_db_peak", {28'd0, bus.db_stable}, 32'h1);
    step(1);
    check("t3_cnt_clr", {29'd0, dut.u_db_right.cnt_q}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_outs", {28'd0, outs()}, 32'h1);
    end

    // 4: left+right -> hazard; dropping right returns to left.
    set_raw(1'b1, 1'b1, 1'b0, 1'b0);
    step(6);
    check("t4_db_lr", {28'd0, bus.db_stable}, 32'h3);
    wait_tick_load("t4_tick_lr");
    check("t4_outs_lr", {28'd0, outs()}, 32'h4);
    set_raw(1'b1, 1'b0, 1'b0, 1'b0);
    step(6);
    check("t4_db_l", {28'd0, bus.db_stable}, 32'h1);
    wait_tick_load("t4_tick_l");
    check("t4_outs_l", {28'd0, outs()}, 32'h1);

    // 5: brake outranks left; hazard outranks brake; full release goes idle.
    set_raw(1'b1, 1'b0, 1'b0, 1'b1);
    step(6);
    check("t5_db_lb", {28'd0, bus.db_stable}, 32'h9);
    wait_tick_load("t5_tick_lb");
    check("t5_outs_lb", {28'd0, outs()}, 32'h8);
    set_raw(1'b1, 1'b0, 1'b1, 1'b1);
    step(6);
    check("t5_db_lbh", {28'd0, bus.db_stable}, 32'hD);
    wait_tick_load("t5_tick_lbh");
    check("t5_outs_lbh", {28'd0, outs()}, 32'h4);
    set_raw(1'b0, 1'b0, 1'b0, 1'b0);
    step(6);
    check("t5_db_none", {28'd0, bus.db_stable}, 32'h0);
    wait_tick_load("t5_tick_none");
    check("t5_outs_none", {28'd0, outs()}, 32'h0);

    // 6: reset with brake active and left count at 2 clears everything immediately.
    set_raw(1'b0, 1'b0, 1'b0, 1'b1);
    step(6);
    wait_tick_load("t6_tick_b");
    check("t6_outs_b", {28'd0, outs()}, 32'h8);
    set_raw(1'b1, 1'b0, 1'b0, 1'b1);
    step(4);
    check("t6_cnt_mid", {29'd0, dut.u_db_left.cnt_q}, 32'd2);
    Reset = 1'b1;
    set_raw(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("t6_rst_outs", {28'd0, outs()}, 32'h0);
    check("t6_rst_tick", {31'd0, bus.tick}, 32'd0);
    check("t6_rst_db", {28'd0, bus.db_stable}, 32'h0);
    check("t6_rst_cnt", {29'd0, dut.u_db_left.cnt_q}, 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    step(5);
    check("t6_db_p5", {28'd0, bus.db_stable}, 32'h0);
    step(1);
    check("t6_db_p6", {28'd0, bus.db_stable}, 32'h1);
    step(1);
    check("t6_tick_p7", {31'd0, bus.tick}, 32'd1);
    check("t6_outs_p7", {28'd0, outs()}, 32'h0);
    step(1);
    check("t6_outs_p8", {28'd0, outs()}, 32'h1);
    check("t6_tick_p8", {31'd0, bus.tick}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
